// File: rtl/bpsk_seq_mod.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_seq_mod
// Brief    : Sequence-coded BPSK mixer. It phase-codes an offset-binary DDS
//            carrier with a stored chip sequence (Barker-13 by default). Each
//            chip lasts SAMPLES_PER_CHIP valid samples, and the code repeats
//            n_rep times (0 = until stop). The output sits at midscale
//            whenever no pulse is active.
//            Optional macro BPSK_SEQ_RAMP_EN: at a chip boundary where the
//            code bit changes, the gain slews 2 per sample instead of
//            flipping hard.
// Revision : 1.0 - initial release
// ============================================================================
module bpsk_seq_mod #(
  parameter int                  DATA_W           = 14,
  parameter int                  CODE_LEN         = 13,
  parameter logic [CODE_LEN-1:0] CODE             = 13'b1111100110101,
  parameter int                  SAMPLES_PER_CHIP = 40,
  parameter int                  RAMP_LOG2        = 3,
  localparam int                 CI_W             = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        n_rep,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] senial,
  output logic [DATA_W-1:0] senial_mod,
  output logic              mod_valid,
  output logic              busy,
  output logic [CI_W-1:0]   chip_idx,
  output logic              done
);

  localparam int SC_W = $clog2(SAMPLES_PER_CHIP);
  localparam int R    = 1 << RAMP_LOG2;
  localparam int GW   = RAMP_LOG2 + 3;
  localparam int PW   = DATA_W + 1 + GW;

  localparam logic [DATA_W-1:0]    MID    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [GW-1:0] G_POS  = GW'(R);
  localparam logic signed [GW-1:0] G_NEG  = GW'(-R);
  localparam logic signed [PW-1:0] MID_W  = PW'(MID);
  localparam logic signed [PW-1:0] MAX_W  = PW'({DATA_W{1'b1}});

  // Chip 0 is the MSB of CODE; reversing lets chip_idx index directly.
  function automatic logic [CODE_LEN-1:0] rev_code(input logic [CODE_LEN-1:0] c);
    for (int i = 0; i < CODE_LEN; i++) rev_code[i] = c[CODE_LEN-1-i];
  endfunction
  localparam logic [CODE_LEN-1:0] CODE_REV = rev_code(CODE);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic [SC_W-1:0]         samp_cnt;
  logic [7:0]              rep_cnt;
  logic [7:0]              n_rep_q;
  logic signed [GW-1:0]    g_tgt;
  logic signed [GW-1:0]    g_cur;
  logic                    take;
  logic                    samp_last;
  logic                    chip_last;
  logic                    rep_last;
  logic                    last_smp;
`ifdef BPSK_SEQ_RAMP_EN
  logic signed [GW-1:0]    g_prev;
  logic signed [GW-1:0]    g_up;
  logic signed [GW-1:0]    g_dn;
`endif

  // Pipeline registers
  logic                    v1;
  logic                    l1;
  logic signed [DATA_W:0]  d1;
  logic signed [GW-1:0]    g1;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    scaled;
  logic signed [PW-1:0]    sum;
  logic [DATA_W-1:0]       y_sat;

  assign busy = (state == RUN);

  // Sample acceptance, end-of-burst detection and the gain for the current sample
  always_comb begin
    take      = (state == RUN) && !stop && sample_valid;
    samp_last = (samp_cnt == SC_W'(SAMPLES_PER_CHIP - 1));
    chip_last = (chip_idx == CI_W'(CODE_LEN - 1));
    rep_last  = (n_rep_q != 8'd0) && (rep_cnt == n_rep_q - 8'd1);
    last_smp  = take && samp_last && chip_last && rep_last;
    g_tgt     = CODE_REV[chip_idx] ? G_POS : G_NEG;
`ifdef BPSK_SEQ_RAMP_EN
    // Slew from the previous sample's gain toward the chip's target.
    g_up = g_prev + GW'(2);
    g_dn = g_prev - GW'(2);
    if (g_prev < g_tgt)      g_cur = (g_up > g_tgt) ? g_tgt : g_up;
    else if (g_prev > g_tgt) g_cur = (g_dn < g_tgt) ? g_tgt : g_dn;
    else                     g_cur = g_prev;
`else
    g_cur = g_tgt;
`endif
  end

  // Burst control FSM: chip/sample/repetition counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      samp_cnt <= '0;
      chip_idx <= '0;
      rep_cnt  <= '0;
      n_rep_q  <= '0;
`ifdef BPSK_SEQ_RAMP_EN
      g_prev   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state    <= RUN;
            n_rep_q  <= n_rep;
            samp_cnt <= '0;
            chip_idx <= '0;
            rep_cnt  <= '0;
`ifdef BPSK_SEQ_RAMP_EN
            // No ramp out of idle: first chip starts at full gain.
            g_prev   <= CODE_REV[0] ? G_POS : G_NEG;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state    <= IDLE;
            samp_cnt <= '0;
            chip_idx <= '0;
          end else if (sample_valid) begin
`ifdef BPSK_SEQ_RAMP_EN
            g_prev <= g_cur;
`endif
            if (samp_last) begin
              samp_cnt <= '0;
              if (chip_last) begin
                chip_idx <= '0;
                rep_cnt  <= rep_cnt + 8'd1;
              end else begin
                chip_idx <= chip_idx + CI_W'(1);
              end
            end else begin
              samp_cnt <= samp_cnt + SC_W'(1);
            end
            if (last_smp) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scale, re-bias and clamp the stage-1 sample
  always_comb begin
    prod   = PW'(d1) * PW'(g1);
    scaled = prod >>> RAMP_LOG2;
    sum    = scaled + MID_W;
    if (sum < 0)          y_sat = '0;
    else if (sum > MAX_W) y_sat = {DATA_W{1'b1}};
    else                  y_sat = sum[DATA_W-1:0];
  end

  // Two-stage datapath: capture (d, g), then multiply/saturate into the output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1         <= 1'b0;
      l1         <= 1'b0;
      d1         <= '0;
      g1         <= '0;
      senial_mod <= MID;
      mod_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      v1 <= take;
      l1 <= last_smp;
      if (take) begin
        d1 <= $signed({1'b0, senial}) - $signed({1'b0, MID});
        g1 <= g_cur;
      end
      mod_valid <= v1;
      done      <= v1 && l1;
      if (v1)                 senial_mod <= y_sat;
      else if (state == IDLE) senial_mod <= MID;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bpsk_seq_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpsk_seq_mod
// Brief    : Directed bench for bpsk_seq_mod. A small instance (2 chips,
//            8 samples/chip, R=4) covers burst shape, saturation and control
//            corner cases. A default instance covers continuous mode and stop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpsk_seq_mod;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Small instance
  logic        s_start = 1'b0, s_stop = 1'b0, s_sv = 1'b0;
  logic [7:0]  s_n_rep = 8'd1;
  logic [13:0] s_senial = 14'd8192;
  logic [13:0] s_senial_mod;
  logic        s_mod_valid, s_busy, s_done;
  logic [0:0]  s_chip_idx;

  // Default instance
  logic        d_start = 1'b0, d_stop = 1'b0, d_sv = 1'b0;
  logic [7:0]  d_n_rep = 8'd0;
  logic [13:0] d_senial = 14'd8192;
  logic [13:0] d_senial_mod;
  logic        d_mod_valid, d_busy, d_done;
  logic [3:0]  d_chip_idx;

  bpsk_seq_mod #(
    .DATA_W(14), .CODE_LEN(2), .CODE(2'b10), .SAMPLES_PER_CHIP(8), .RAMP_LOG2(2)
  ) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .n_rep(s_n_rep),
    .sample_valid(s_sv), .senial(s_senial), .senial_mod(s_senial_mod),
    .mod_valid(s_mod_valid), .busy(s_busy), .chip_idx(s_chip_idx), .done(s_done)
  );

  bpsk_seq_mod dut_d (
    .clk(clk), .rst(rst), .start(d_start), .stop(d_stop), .n_rep(d_n_rep),
    .sample_valid(d_sv), .senial(d_senial), .senial_mod(d_senial_mod),
    .mod_valid(d_mod_valid), .busy(d_busy), .chip_idx(d_chip_idx), .done(d_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitors
  logic [13:0] sq[$];
  logic        sdq[$];
  int          s_done_cnt = 0;
  int          d_done_cnt = 0;
  int          wraps = 0;
  logic [3:0]  prev_ci = 4'd0;

  always @(negedge clk) begin
    if (s_mod_valid) begin
      sq.push_back(s_senial_mod);
      sdq.push_back(s_done);
    end
    if (s_done) s_done_cnt++;
    if (d_done) d_done_cnt++;
    if (prev_ci == 4'd12 && d_chip_idx == 4'd0) wraps++;
    prev_ci = d_chip_idx;
  end

`ifdef BPSK_SEQ_RAMP_EN
  int exp2[16] = '{10000, 10000, 10000, 10000, 10000, 10000, 10000, 10000,
                   9096, 8192, 7288, 6384, 6384, 6384, 6384, 6384};
`else
  int exp2[16] = '{10000, 10000, 10000, 10000, 10000, 10000, 10000, 10000,
                   6384, 6384, 6384, 6384, 6384, 6384, 6384, 6384};
`endif

  task automatic small_burst(input logic [13:0] val, input bit dbl_start);
    s_senial = val;
    s_n_rep  = 8'd1;
    s_sv     = 1'b1;
    s_start  = 1'b1;
    tick();
    s_start  = 1'b0;
    if (dbl_start) begin
      tick(3);
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
    end
    for (int i = 0; i < 200 && s_busy; i++) tick();
    chk("burst_end_busy", s_busy, 0);
    tick(4);
  endtask

  initial begin
    int b, bd, wb, db;

    // Reset held while sample_valid toggles
    for (int i = 0; i < 6; i++) begin
      s_sv = i[0];
      d_sv = i[0];
      tick();
    end
    chk("rst_mod", s_senial_mod, 8192);
    chk("rst_valid", s_mod_valid, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_dmod", d_senial_mod, 8192);
    chk("rst_chip", d_chip_idx, 0);
    rst = 1'b1;
    tick(3);
    chk("rel_mod", s_senial_mod, 8192);
    chk("rel_valid", s_mod_valid, 0);
    chk("rel_busy", d_busy, 0);

    // Basic two-chip burst
    b  = sq.size();
    bd = s_done_cnt;
    small_burst(14'd10000, 1'b0);
    chk("burst_len", sq.size() - b, 16);
    for (int i = 0; i < 16; i++) begin
      if (b + i < sq.size()) begin
        chk("burst_smp", sq[b+i], exp2[i]);
        chk("burst_done", sdq[b+i], (i == 15) ? 1 : 0);
      end
    end
    chk("burst_done_cnt", s_done_cnt - bd, 1);
    chk("idle_mid", s_senial_mod, 8192);
    chk("idle_valid", s_mod_valid, 0);

    // Saturation on the inverted chip
    b = sq.size();
    small_burst(14'd0, 1'b0);
    chk("sat0_len", sq.size() - b, 16);
    if (sq.size() >= b + 16) begin
      chk("sat0_first", sq[b], 0);
      chk("sat0_last", sq[b+15], 16383);
    end
    b = sq.size();
    small_burst(14'd16383, 1'b0);
    chk("satf_len", sq.size() - b, 16);
    if (sq.size() >= b + 16) begin
      chk("satf_first", sq[b], 16383);
      chk("satf_last", sq[b+15], 1);
    end

    // start while busy is ignored
    b  = sq.size();
    bd = s_done_cnt;
    small_burst(14'd10000, 1'b1);
    chk("dbl_len", sq.size() - b, 16);
    chk("dbl_done_cnt", s_done_cnt - bd, 1);

    // start and stop together in IDLE: stop wins
    b = sq.size();
    s_start = 1'b1;
    s_stop  = 1'b1;
    tick();
    s_start = 1'b0;
    s_stop  = 1'b0;
    tick(3);
    chk("ss_busy", s_busy, 0);
    chk("ss_len", sq.size() - b, 0);

    // Continuous mode on the default instance, stopped mid chip 5
    d_senial = 14'd12000;
    d_n_rep  = 8'd0;
    d_sv     = 1'b1;
    wb = wraps;
    db = d_done_cnt;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tick(3);
    chk("cont_first", d_senial_mod, 12000);
    chk("cont_valid", d_mod_valid, 1);
    for (int i = 0; i < 3000 && !((wraps - wb) == 3 && d_chip_idx == 4'd5); i++) tick();
    chk("cont_reach", d_chip_idx, 5);
    tick(20);
    chk("cont_chip5", d_senial_mod, 4384);
    d_stop = 1'b1;
    tick();
    d_stop = 1'b0;
    chk("stop_busy", d_busy, 0);
    tick(4);
    chk("stop_mid", d_senial_mod, 8192);
    chk("stop_valid", d_mod_valid, 0);
    chk("stop_wraps", wraps - wb, 3);
    chk("stop_nodone", d_done_cnt - db, 0);

    // Reset mid-burst
    s_senial = 14'd10000;
    s_start  = 1'b1;
    tick();
    s_start  = 1'b0;
    tick(5);
    chk("mid_busy_pre", s_busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_busy", s_busy, 0);
    chk("mid_mod", s_senial_mod, 8192);
    chk("mid_valid", s_mod_valid, 0);
    chk("mid_chip", s_chip_idx, 0);
    tick(2);
    rst = 1'b1;
    tick(3);
    chk("post_busy", s_busy, 0);
    chk("post_valid", s_mod_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
